// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle phase controller for the picoMIPS core.
// Walks each instruction through FETCH, optional memory WAIT, EXEC and WB.
// Generates the PC, program-memory and register-file strobes, and provides
// debug run control: free-run, single-step, PC breakpoint and a halt on a
// branch to its own address.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_HALT  | idle; waits for step, or run with no sticky stop flag set
//   S_FETCH | program-memory address strobe (fetch_en)
//   S_WAIT  | MEM_LATENCY cycles for synchronous program memory
//   S_EXEC  | operands valid (exec_en)
//   S_WB    | result written back, PC advanced, stop rules evaluated
//
// Encodings 5..7 are unreachable and fall back to S_HALT.
module cpu_sequencer #(
  parameter int PC_WIDTH    = 8,
  parameter int MEM_LATENCY = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic                 step,
  input  logic                 bp_en,
  input  logic [PC_WIDTH-1:0]  bp_addr,
  input  logic [PC_WIDTH-1:0]  pc_addr,
  input  logic                 branch,
  input  logic [PC_WIDTH-1:0]  branch_addr,
  output logic                 fetch_en,
  output logic                 exec_en,
  output logic                 wr_en,
  output logic                 pc_inc,
  output logic                 pc_load,
  output logic [2:0]           phase,
  output logic                 halted,
  output logic                 bp_hit,
  output logic                 self_loop,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_HALT  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EXEC  = 3'd3,
    S_WB    = 3'd4
  } state_t;

  // Wait timer is a down-counter loaded on FETCH; EXEC follows at terminal count 0.
  localparam logic [2:0] WAIT_INIT = (MEM_LATENCY > 0) ? 3'(MEM_LATENCY - 1) : 3'd0;

  state_t                 state_q, state_d;
  logic [2:0]             wait_cnt_q, wait_cnt_d;
  logic                   step_mode_q, step_mode_d;
  logic                   bp_hit_q, bp_hit_d;
  logic                   self_loop_q, self_loop_d;
  logic [CNT_WIDTH-1:0]   instr_count_q, instr_count_d;
  logic                   fetch_en_q, fetch_en_d;
  logic                   exec_en_q, exec_en_d;
  logic                   wr_en_q, wr_en_d;
  logic                   halted_q, halted_d;

  logic [PC_WIDTH-1:0]    next_pc;
  logic                   loop_now;
  logic                   bp_now;

  // Next-state, sticky-flag and counter logic; output strobes are decoded
  // from the next state so they register in step with the phase.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    step_mode_d   = step_mode_q;
    bp_hit_d      = bp_hit_q;
    self_loop_d   = self_loop_q;
    instr_count_d = instr_count_q;
    next_pc       = branch ? branch_addr : (pc_addr + PC_WIDTH'(1));
    loop_now      = 1'b0;
    bp_now        = 1'b0;

    case (state_q)
      S_HALT: begin
        if (step || (run && !bp_hit_q && !self_loop_q)) begin
          state_d     = S_FETCH;
          // Anything other than a clean free-run start executes one instruction only.
          step_mode_d = step || !run || bp_hit_q || self_loop_q;
          bp_hit_d    = 1'b0;
          self_loop_d = 1'b0;
        end else if (!run) begin
          // Dropping run re-arms free-running for the next rising edge of run.
          bp_hit_d    = 1'b0;
          self_loop_d = 1'b0;
        end
      end
      S_FETCH: begin
        if (MEM_LATENCY > 0) begin
          state_d    = S_WAIT;
          wait_cnt_d = WAIT_INIT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == 3'd0) begin
          state_d = S_EXEC;
        end else begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
      end
      S_WB: begin
        loop_now      = branch && (branch_addr == pc_addr);
        bp_now        = bp_en && (next_pc == bp_addr);
        self_loop_d   = self_loop_q | loop_now;
        bp_hit_d      = bp_hit_q | bp_now;
        instr_count_d = instr_count_q + CNT_WIDTH'(1);
        if (step_mode_q || !run || loop_now || bp_now) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_HALT;
      end
    endcase

    fetch_en_d = (state_d == S_FETCH);
    exec_en_d  = (state_d == S_EXEC) || (state_d == S_WB);
    wr_en_d    = (state_d == S_WB);
    halted_d   = (state_d == S_HALT);
  end

  // All sequencer state and registered strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_HALT;
      wait_cnt_q    <= 3'd0;
      step_mode_q   <= 1'b0;
      bp_hit_q      <= 1'b0;
      self_loop_q   <= 1'b0;
      instr_count_q <= '0;
      fetch_en_q    <= 1'b0;
      exec_en_q     <= 1'b0;
      wr_en_q       <= 1'b0;
      halted_q      <= 1'b1;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      step_mode_q   <= step_mode_d;
      bp_hit_q      <= bp_hit_d;
      self_loop_q   <= self_loop_d;
      instr_count_q <= instr_count_d;
      fetch_en_q    <= fetch_en_d;
      exec_en_q     <= exec_en_d;
      wr_en_q       <= wr_en_d;
      halted_q      <= halted_d;
    end
  end

  // PC strobes qualify the registered WB window with the branch decision,
  // so exactly one of them is high during WB and neither at any other time.
  assign pc_load     = wr_en_q & branch;
  assign pc_inc      = wr_en_q & ~branch;

  assign fetch_en    = fetch_en_q;
  assign exec_en     = exec_en_q;
  assign wr_en       = wr_en_q;
  assign phase       = state_q;
  assign halted      = halted_q;
  assign bp_hit      = bp_hit_q;
  assign self_loop   = self_loop_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: main instance with MEM_LATENCY=1 and a
// second instance with MEM_LATENCY=0 and a 2-bit counter to reach the wrap.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       run, step, bp_en, branch;
  logic [7:0] bp_addr, pc_addr, branch_addr;

  logic        fetch_en, exec_en, wr_en, pc_inc, pc_load, halted, bp_hit, self_loop;
  logic [2:0]  phase;
  logic [15:0] instr_count;

  logic        run_w;
  logic        w_fetch_en, w_exec_en, w_wr_en, w_pc_inc, w_pc_load, w_halted, w_bp_hit, w_self_loop;
  logic [2:0]  w_phase;
  logic [1:0]  w_instr_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(.PC_WIDTH(8), .MEM_LATENCY(1), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .step(step),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc_addr(pc_addr),
    .branch(branch), .branch_addr(branch_addr),
    .fetch_en(fetch_en), .exec_en(exec_en), .wr_en(wr_en),
    .pc_inc(pc_inc), .pc_load(pc_load), .phase(phase),
    .halted(halted), .bp_hit(bp_hit), .self_loop(self_loop),
    .instr_count(instr_count)
  );

  cpu_sequencer #(.PC_WIDTH(8), .MEM_LATENCY(0), .CNT_WIDTH(2)) dut_w (
    .clk(clk), .reset_n(reset_n), .run(run_w), .step(1'b0),
    .bp_en(1'b0), .bp_addr(8'h00), .pc_addr(8'h00),
    .branch(1'b0), .branch_addr(8'h00),
    .fetch_en(w_fetch_en), .exec_en(w_exec_en), .wr_en(w_wr_en),
    .pc_inc(w_pc_inc), .pc_load(w_pc_load), .phase(w_phase),
    .halted(w_halted), .bp_hit(w_bp_hit), .self_loop(w_self_loop),
    .instr_count(w_instr_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock, then settle away from the edge before checking or driving.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Phase plus all strobes of the main instance.
  task automatic chk_ph(input string tag, input int ph, input bit fe, input bit ee,
                        input bit we, input bit pi, input bit pl);
    chk({tag, "_phase"},    32'(phase),    32'(ph));
    chk({tag, "_fetch_en"}, 32'(fetch_en), 32'(fe));
    chk({tag, "_exec_en"},  32'(exec_en),  32'(ee));
    chk({tag, "_wr_en"},    32'(wr_en),    32'(we));
    chk({tag, "_pc_inc"},   32'(pc_inc),   32'(pi));
    chk({tag, "_pc_load"},  32'(pc_load),  32'(pl));
    chk({tag, "_halted"},   32'(halted),   32'(ph == 0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; run = 1'b0; step = 1'b0; bp_en = 1'b0; branch = 1'b0;
    bp_addr = 8'h00; pc_addr = 8'h00; branch_addr = 8'h00; run_w = 1'b0;
    cyc(); cyc();

    // Reset state
    chk_ph("rst", 0, 0, 0, 0, 0, 0);
    chk("rst_count", 32'(instr_count), 32'd0);
    chk("rst_bp_hit", 32'(bp_hit), 32'd0);
    chk("rst_self_loop", 32'(self_loop), 32'd0);
    chk("rst_w_phase", 32'(w_phase), 32'd0);

    reset_n = 1'b1;
    cyc();
    chk_ph("idle", 0, 0, 0, 0, 0, 0);

    // Zero-latency instance: FETCH, EXEC, WB; 2-bit counter wraps after 4.
    run_w = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("w%0d_fetch", i), 32'(w_phase), 32'd1);
      chk($sformatf("w%0d_count", i), 32'(w_instr_count), 32'(i));
      cyc();
      chk($sformatf("w%0d_exec", i), 32'(w_phase), 32'd3);
      cyc();
      chk($sformatf("w%0d_wb", i), 32'(w_phase), 32'd4);
      chk($sformatf("w%0d_wr", i), 32'(w_wr_en), 32'd1);
      if (i == 3) run_w = 1'b0;
    end
    cyc();
    chk("w_halt", 32'(w_phase), 32'd0);
    chk("w_wrap", 32'(w_instr_count), 32'd0);

    // Free run, four sequential instructions
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk_ph($sformatf("run%0d_fetch", i), 1, 1, 0, 0, 0, 0);
      chk($sformatf("run%0d_count", i), 32'(instr_count), 32'(i));
      cyc();
      chk_ph($sformatf("run%0d_wait", i), 2, 0, 0, 0, 0, 0);
      cyc();
      chk_ph($sformatf("run%0d_exec", i), 3, 0, 1, 0, 0, 0);
      cyc();
      chk_ph($sformatf("run%0d_wb", i), 4, 0, 1, 1, 1, 0);
      pc_addr = 8'(i + 1);
      if (i == 3) run = 1'b0;
    end
    cyc();
    chk_ph("run_stop", 0, 0, 0, 0, 0, 0);
    chk("run_count", 32'(instr_count), 32'd4);

    // Single step; a step during EXEC is ignored
    step = 1'b1;
    cyc();
    step = 1'b0;
    chk_ph("st_fetch", 1, 1, 0, 0, 0, 0);
    cyc();
    chk_ph("st_wait", 2, 0, 0, 0, 0, 0);
    cyc();
    chk_ph("st_exec", 3, 0, 1, 0, 0, 0);
    step = 1'b1;
    cyc();
    step = 1'b0;
    chk_ph("st_wb", 4, 0, 1, 1, 1, 0);
    cyc();
    chk_ph("st_halt", 0, 0, 0, 0, 0, 0);
    chk("st_count", 32'(instr_count), 32'd5);
    cyc();
    chk_ph("st_stay", 0, 0, 0, 0, 0, 0);

    // Branch to own address halts and sticks while run stays high
    pc_addr = 8'h05; branch = 1'b1; branch_addr = 8'h05; run = 1'b1;
    cyc(); cyc(); cyc();
    chk_ph("sl_exec", 3, 0, 1, 0, 0, 0);
    cyc();
    chk_ph("sl_wb", 4, 0, 1, 1, 0, 1);
    cyc();
    chk_ph("sl_halt", 0, 0, 0, 0, 0, 0);
    chk("sl_flag", 32'(self_loop), 32'd1);
    chk("sl_count", 32'(instr_count), 32'd6);
    cyc();
    chk("sl_stay_phase", 32'(phase), 32'd0);
    chk("sl_stay_flag", 32'(self_loop), 32'd1);
    run = 1'b0;
    cyc();
    chk("sl_clear", 32'(self_loop), 32'd0);
    chk("sl_clear_phase", 32'(phase), 32'd0);
    branch = 1'b0; run = 1'b1;
    cyc();
    chk_ph("sl_resume", 1, 1, 0, 0, 0, 0);

    // run dropped during WAIT: instruction still completes
    cyc();
    chk_ph("rw_wait", 2, 0, 0, 0, 0, 0);
    run = 1'b0;
    cyc();
    chk_ph("rw_exec", 3, 0, 1, 0, 0, 0);
    cyc();
    chk_ph("rw_wb", 4, 0, 1, 1, 1, 0);
    cyc();
    chk_ph("rw_halt", 0, 0, 0, 0, 0, 0);
    chk("rw_count", 32'(instr_count), 32'd7);

    // Breakpoint on next PC 0x10, then step one instruction at 0x10
    bp_en = 1'b1; bp_addr = 8'h10; pc_addr = 8'h0F; run = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    chk_ph("bp_wb", 4, 0, 1, 1, 1, 0);
    cyc();
    chk_ph("bp_halt", 0, 0, 0, 0, 0, 0);
    chk("bp_flag", 32'(bp_hit), 32'd1);
    chk("bp_sl", 32'(self_loop), 32'd0);
    chk("bp_count", 32'(instr_count), 32'd8);
    cyc();
    chk("bp_stay", 32'(phase), 32'd0);
    pc_addr = 8'h10; step = 1'b1;
    cyc();
    step = 1'b0;
    chk_ph("bps_fetch", 1, 1, 0, 0, 0, 0);
    chk("bps_clear", 32'(bp_hit), 32'd0);
    cyc(); cyc(); cyc();
    chk_ph("bps_wb", 4, 0, 1, 1, 1, 0);
    run = 1'b0; bp_en = 1'b0;
    cyc();
    chk_ph("bps_halt", 0, 0, 0, 0, 0, 0);
    chk("bps_count", 32'(instr_count), 32'd9);
    chk("bps_flag", 32'(bp_hit), 32'd0);

    // Reset asserted during EXEC aborts immediately
    pc_addr = 8'h20; run = 1'b1;
    cyc(); cyc(); cyc();
    chk_ph("ra_exec", 3, 0, 1, 0, 0, 0);
    reset_n = 1'b0;
    #1;
    chk_ph("ra_abort", 0, 0, 0, 0, 0, 0);
    chk("ra_count", 32'(instr_count), 32'd0);
    run = 1'b0;
    cyc();
    chk_ph("ra_hold", 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    cyc();
    chk_ph("ra_idle", 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle phase controller for the picoMIPS core; replaces the free-running cycle generator.
- Steps each instruction through fetch, memory wait, execute and writeback, and generates the PC, register-file and program-memory enables.
- Adds debug run control: run, single-step, PC breakpoint, and automatic halt on a taken branch to its own address (end-of-program idiom).
- Sits between the PC, the program memory, the register file and the SUBLEQ/MULTI result mux.

Parameters:
- PC_WIDTH, 8, width of program counter / branch address.
- MEM_LATENCY, 1, extra wait cycles after FETCH for synchronous program memory (0..7; 0 skips WAIT).
- CNT_WIDTH, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  level; free-run while high
- step  in  1  single-cycle pulse; execute exactly one instruction from HALT
- bp_en  in  1  breakpoint enable
- bp_addr  in  PC_WIDTH  breakpoint PC
- pc_addr  in  PC_WIDTH  current PC from pc block
- branch  in  1  branch decision from result mux (valid in EXEC/WB)
- branch_addr  in  PC_WIDTH  branch target from instruction
- fetch_en  out  1  program-memory address strobe
- exec_en  out  1  operands/result valid window
- wr_en  out  1  register writeback enable
- pc_inc  out  1  PC increment
- pc_load  out  1  PC load branch_addr
- phase  out  3  state encoding (HALT=0, FETCH=1, WAIT=2, EXEC=3, WB=4)
- halted  out  1  high in HALT
- bp_hit  out  1  sticky: stopped on breakpoint
- self_loop  out  1  sticky: stopped on self-branch
- instr_count  out  CNT_WIDTH  retired instructions

Behaviour:
Reset (async, reset_n=0):
- State HALT; halted=1; all enables 0; instr_count=0; bp_hit=0; self_loop=0; step_mode=0; wait counter 0.
- Deassertion is sampled synchronously; first transition possible on the first edge after release.

HALT:
- Exit to FETCH when step=1, or when run=1 and bp_hit=0 and self_loop=0.
- step_mode is latched as 1 if the exit was by step, or if run=0 or a sticky flag was set; otherwise 0.
- bp_hit and self_loop clear on leaving HALT.
- Both sticky flags also clear whenever run=0 in HALT, so a run low→high re-arms free-running.
- step while not in HALT is ignored.

Phase sequence:
- FETCH: one cycle, fetch_en=1. Next state is WAIT if MEM_LATENCY>0, else EXEC.
- WAIT: exactly MEM_LATENCY cycles, all enables 0; then EXEC.
- EXEC: one cycle, exec_en=1; then WB.
- WB: one cycle.
  - exec_en=1, wr_en=1.
  - pc_load=branch, pc_inc=!branch; exactly one of the two is high.
  - instr_count += 1, wrapping from all-ones to 0.
- Every instruction therefore takes 3+MEM_LATENCY cycles.

Next-PC and stop rules, evaluated in WB:
- next_pc = branch ? branch_addr : pc_addr+1 (mod 2^PC_WIDTH).
- self-loop = branch && branch_addr==pc_addr → set self_loop.
- bp_en && next_pc==bp_addr → set bp_hit. If both conditions hold, both flags set.
- Next state is HALT if step_mode, or run=0, or a flag was set this cycle; else FETCH.
- run falling mid-instruction: the current instruction completes through WB, then HALT. No partial instruction ever occurs.
- reset_n asserted mid-instruction: immediate abort; no wr_en/pc pulse is issued in that cycle.

Output timing and encoding:
- All outputs are registered or decoded from state only; no combinational path from run/step to outputs.
- Unused phase codes 5–7 recover to HALT.

Test Plan:
- Reset then run=1, MEM_LATENCY=1, branch=0, pc_addr stepping 0..3 → phase 1,2,3,4 repeating, pc_inc every 4th cycle, instr_count=4 after 16 cycles, wr_en one cycle per instruction.
- run=0, single step pulse from HALT → exactly one FETCH..WB, one wr_en, one pc_inc, back in HALT with halted=1, instr_count=1; a second step during EXEC is ignored.
- run=1, pc_addr=5, branch=1, branch_addr=5 in WB → pc_load=1, self_loop=1, HALT; run held high stays halted; run 0→1 resumes FETCH.
- bp_en=1, bp_addr=0x10, pc_addr=0x0F, branch=0 → after WB bp_hit=1, HALT; step executes one instruction at 0x10 and returns to HALT.
- run deasserted during WAIT → WB still completes (wr_en=1, pc_inc=1), then HALT.
- reset_n pulsed low during EXEC → same cycle phase=0, no wr_en/pc pulse; instr_count=0. Separately, preload instr_count at 0xFFFF → wraps to 0x0000 after one WB.
